// File: rtl/video_pkg.sv
// Shared types and default timing for the video source and the downstream filter stages.
package video_pkg;

    localparam int unsigned PIX_W       = 8;
    localparam int unsigned H_RES_DEF   = 176;
    localparam int unsigned H_BLANK_DEF = 16;
    localparam int unsigned HS_W_DEF    = 8;
    localparam int unsigned V_RES_DEF   = 144;
    localparam int unsigned V_BLANK_DEF = 4;

    typedef logic [PIX_W-1:0] pixel_t;

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

endpackage

// File: rtl/video_stream_src_if.sv
// Pixel stream bundle (vsync/hsync/de/data) passed from the source to the filter pipeline.
interface video_stream_src_if
    import video_pkg::*;
#(
    parameter int unsigned WIDTH = PIX_W
) ();

    logic             vsync;
    logic             hsync;
    logic             de;
    logic [WIDTH-1:0] data;

    modport master (output vsync, hsync, de, data);
    modport slave  (input  vsync, hsync, de, data);

endinterface

// File: rtl/video_timing_cnt.sv
// Horizontal/vertical counters with raw sync, data-enable and end-of-frame flags.
// With VIDEO_STREAM_SRC_PATTERN_EN it also produces the (col + row) test-pattern pixel.
module video_timing_cnt
    import video_pkg::*;
#(
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    parameter int unsigned WIDTH   = PIX_W,
`endif
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned H_BLANK = H_BLANK_DEF,
    parameter int unsigned HS_W    = HS_W_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned V_BLANK = V_BLANK_DEF
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             clear_i,
    input  logic             run_i,
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    output logic [WIDTH-1:0] pat_o,
`endif
    output logic             vsync_o,
    output logic             hsync_o,
    output logic             de_o,
    output logic             eof_o
);

    localparam int unsigned H_TOTAL = H_RES + H_BLANK;
    localparam int unsigned V_TOTAL = V_BLANK + V_RES;
    localparam int unsigned HW      = $clog2(H_TOTAL);
    localparam int unsigned VW      = $clog2(V_TOTAL);

    localparam logic [HW-1:0] HLast = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] VLast = VW'(V_TOTAL - 1);

    logic [HW-1:0] h_cnt_q, h_cnt_d;
    logic [VW-1:0] v_cnt_q, v_cnt_d;
    logic [31:0]   h_ext, v_ext;

    always_comb begin
        h_cnt_d = h_cnt_q;
        v_cnt_d = v_cnt_q;
        if (clear_i) begin
            h_cnt_d = '0;
            v_cnt_d = '0;
        end else if (run_i) begin
            if (h_cnt_q == HLast) begin
                h_cnt_d = '0;
                v_cnt_d = (v_cnt_q == VLast) ? '0 : v_cnt_q + 1'b1;
            end else begin
                h_cnt_d = h_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            h_cnt_q <= '0;
            v_cnt_q <= '0;
        end else begin
            h_cnt_q <= h_cnt_d;
            v_cnt_q <= v_cnt_d;
        end
    end

    // 32-bit copies keep the comparisons against the int parameters width-clean.
    assign h_ext = 32'(h_cnt_q);
    assign v_ext = 32'(v_cnt_q);

    assign vsync_o = run_i && (v_cnt_q == '0);
    assign hsync_o = run_i && (h_ext >= H_RES) && (h_ext < H_RES + HS_W);
    assign de_o    = run_i && (v_ext >= V_BLANK) && (h_ext < H_RES);
    assign eof_o   = run_i && (h_cnt_q == HLast) && (v_cnt_q == VLast);

`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    assign pat_o = WIDTH'(h_ext + v_ext - V_BLANK);
`endif

endmodule

// File: rtl/video_stream_src.sv
// Frame-buffer reader and video timing generator: emits one frame per accepted start request.
// Optional VIDEO_STREAM_SRC_PATTERN_EN adds i_pattern to replace memory data by (col + row).
module video_stream_src
    import video_pkg::*;
#(
    parameter int unsigned WIDTH   = PIX_W,
    parameter int unsigned H_RES   = H_RES_DEF,
    parameter int unsigned H_BLANK = H_BLANK_DEF,
    parameter int unsigned HS_W    = HS_W_DEF,
    parameter int unsigned V_RES   = V_RES_DEF,
    parameter int unsigned V_BLANK = V_BLANK_DEF,
    parameter int unsigned ADDR_W  = $clog2(H_RES * V_RES)
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              i_start,
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    input  logic              i_pattern,
`endif
    output logic              o_busy,
    output logic              o_frame_done,
    output logic              o_rd_en,
    output logic [ADDR_W-1:0] o_rd_addr,
    input  logic [WIDTH-1:0]  i_rd_data,
    video_stream_src_if.master vid_o
);

    state_e            state_q, state_d;
    logic              drain_q, drain_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              start_acc;
    logic              run;
    logic              mem_mode;

    logic              vs_raw, hs_raw, de_raw, eof;
    logic              s1_vs_q, s1_hs_q, s1_de_q;
    logic              vs_q, hs_q, de_q;
    logic [WIDTH-1:0]  data_q, data_d;

`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    logic              pattern_q;
    logic [WIDTH-1:0]  pat_raw, s1_pat_q;
`endif

    video_timing_cnt #(
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
        .WIDTH   (WIDTH),
`endif
        .H_RES   (H_RES),
        .H_BLANK (H_BLANK),
        .HS_W    (HS_W),
        .V_RES   (V_RES),
        .V_BLANK (V_BLANK)
    ) u_timing (
        .clk     (clk),
        .rstn    (rstn),
        .clear_i (start_acc),
        .run_i   (run),
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
        .pat_o   (pat_raw),
`endif
        .vsync_o (vs_raw),
        .hsync_o (hs_raw),
        .de_o    (de_raw),
        .eof_o   (eof)
    );

    // drain_q distinguishes the first (0) and second (1) DRAIN cycle.
    always_comb begin
        state_d   = state_q;
        drain_d   = drain_q;
        start_acc = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (i_start) begin
                    state_d   = StRun;
                    start_acc = 1'b1;
                end
            end
            StRun: begin
                if (eof) begin
                    state_d = StDrain;
                    drain_d = 1'b0;
                end
            end
            StDrain: begin
                drain_d = 1'b1;
                if (drain_q) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    assign run          = (state_q == StRun);
    assign o_busy       = (state_q != StIdle);
    assign o_frame_done = (state_q == StDrain) && drain_q;

`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    assign mem_mode = !pattern_q;
`else
    assign mem_mode = 1'b1;
`endif

    assign o_rd_en   = de_raw && mem_mode;
    assign o_rd_addr = addr_q;

    always_comb begin
        addr_d = addr_q;
        if (start_acc) begin
            addr_d = '0;
        end else if (de_raw) begin
            addr_d = addr_q + 1'b1;
        end
    end

    // Read data arrives alongside stage 1, so the output register lands 2 cycles after raw.
    always_comb begin
        data_d = '0;
        if (s1_de_q) begin
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
            data_d = pattern_q ? s1_pat_q : i_rd_data;
`else
            data_d = i_rd_data;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q <= StIdle;
            drain_q <= 1'b0;
            addr_q  <= '0;
            s1_vs_q <= 1'b0;
            s1_hs_q <= 1'b0;
            s1_de_q <= 1'b0;
            vs_q    <= 1'b0;
            hs_q    <= 1'b0;
            de_q    <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            drain_q <= drain_d;
            addr_q  <= addr_d;
            s1_vs_q <= vs_raw;
            s1_hs_q <= hs_raw;
            s1_de_q <= de_raw;
            vs_q    <= s1_vs_q;
            hs_q    <= s1_hs_q;
            de_q    <= s1_de_q;
            data_q  <= data_d;
        end
    end

`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            pattern_q <= 1'b0;
            s1_pat_q  <= '0;
        end else begin
            if (start_acc) begin
                pattern_q <= i_pattern;
            end
            s1_pat_q <= pat_raw;
        end
    end
`endif

    assign vid_o.vsync = vs_q;
    assign vid_o.hsync = hs_q;
    assign vid_o.de    = de_q;
    assign vid_o.data  = data_q;

endmodule

// File: tb/tb_video_stream_src.sv
// Self-checking bench for video_stream_src: frame traces compared against a geometric model.
module tb_video_stream_src;

    localparam int H_RES   = 176;
    localparam int H_BLANK = 16;
    localparam int HS_W    = 8;
    localparam int V_RES   = 144;
    localparam int V_BLANK = 4;
    localparam int H_TOT   = H_RES + H_BLANK;
    localparam int V_TOT   = V_BLANK + V_RES;
    localparam int FRAME   = H_TOT * V_TOT;
    localparam int NPIX    = H_RES * V_RES;
    localparam int NCAP    = FRAME + 12;

    localparam int F_BUSY = 0, F_DONE = 1, F_RDEN = 2, F_ADDR = 3;
    localparam int F_VS = 4, F_HS = 5, F_DE = 6, F_DATA = 7;

    typedef struct packed {
        logic        busy;
        logic        done;
        logic        rden;
        logic [14:0] addr;
        logic        vs;
        logic        hs;
        logic        de;
        logic [7:0]  data;
    } sample_t;

    typedef struct {
        string       name;
        int          cyc;
        int          fld;
        logic [31:0] val;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        busy, done, rd_en;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data = 8'h00;
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
    logic        pattern = 1'b0;
`endif

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] mem [NPIX];
    sample_t    trace [NCAP];
    vec_t       tbl [$];

    video_stream_src_if #(.WIDTH(8)) vid ();

    video_stream_src dut (
        .clk          (clk),
        .rstn         (rstn),
        .i_start      (start),
`ifdef VIDEO_STREAM_SRC_PATTERN_EN
        .i_pattern    (pattern),
`endif
        .o_busy       (busy),
        .o_frame_done (done),
        .o_rd_en      (rd_en),
        .o_rd_addr    (rd_addr),
        .i_rd_data    (rd_data),
        .vid_o        (vid)
    );

    initial forever #5 clk = ~clk;

    // Synchronous BRAM model; junk on the bus whenever no read was issued.
    always @(posedge clk) begin
        if (rd_en && int'(rd_addr) < NPIX) rd_data <= mem[int'(rd_addr)];
        else                               rd_data <= 8'($urandom);
    end

    function automatic sample_t sample_now();
        return {busy, done, rd_en, rd_addr, vid.vsync, vid.hsync, vid.de, vid.data};
    endfunction

    // Expected outputs for cycle c of a frame, from line/pixel geometry alone.
    function automatic sample_t model(input int c, input bit pat);
        sample_t s = '0;
        int t, h, v;
        s.busy = (c >= 0) && (c <= FRAME + 1);
        s.done = (c == FRAME + 1);
        if (c >= 0 && c < FRAME) begin
            v = c / H_TOT;
            h = c % H_TOT;
            if (v >= V_BLANK && h < H_RES && !pat) begin
                s.rden = 1'b1;
                s.addr = 15'((v - V_BLANK) * H_RES + h);
            end
        end
        t = c - 2;
        if (t >= 0 && t < FRAME) begin
            v = t / H_TOT;
            h = t % H_TOT;
            s.vs = (v == 0);
            s.hs = (h >= H_RES) && (h < H_RES + HS_W);
            s.de = (v >= V_BLANK) && (h < H_RES);
            if (s.de) s.data = pat ? 8'(h + v - V_BLANK) : mem[(v - V_BLANK) * H_RES + h];
        end
        return s;
    endfunction

    function automatic logic [31:0] field(input sample_t s, input int f);
        case (f)
            F_BUSY:  return 32'(s.busy);
            F_DONE:  return 32'(s.done);
            F_RDEN:  return 32'(s.rden);
            F_ADDR:  return 32'(s.addr);
            F_VS:    return 32'(s.vs);
            F_HS:    return 32'(s.hs);
            F_DE:    return 32'(s.de);
            default: return 32'(s.data);
        endcase
    endfunction

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", name, cyc, act, want);
        end
    endtask

    task automatic start_frame();
        repeat ($urandom_range(1, 5)) @(negedge clk);
        chk("idle_before_start", -1, 32'(busy), 32'd0);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Records cycle c (c = 0 is the first RUN cycle); optionally pokes start at 5000 and frame_done.
    task automatic capture(input int n, input bit poke);
        for (int c = 0; c < n; c++) begin
            trace[c] = sample_now();
            start = poke && (c == 5000 || c == FRAME + 1);
            @(negedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_model(input string tag, input int n, input bit pat);
        sample_t a, e;
        for (int c = 0; c < n; c++) begin
            a = trace[c];
            e = model(c, pat);
            if (!e.rden) a.addr = '0;
            chk(tag, c, 32'(a), 32'(e));
        end
    endtask

    task automatic check_table();
        for (int i = 0; i < tbl.size(); i++) begin
            chk(tbl[i].name, tbl[i].cyc, field(trace[tbl[i].cyc], tbl[i].fld), tbl[i].val);
        end
    endtask

    initial begin
        int n_de, n_rd, n_vs, n_hsp, n_bad;

        repeat (3) @(negedge clk);
        rstn = 1'b1;
        chk("reset_outputs", 0, 32'(sample_now()), 32'd0);

        // Frame 1: ramp memory, start re-poked mid-frame and on frame_done.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'(i);
        tbl = '{};
        tbl.push_back('{"busy_c0",         0,     F_BUSY, 1});
        tbl.push_back('{"vs_pre",          1,     F_VS,   0});
        tbl.push_back('{"vs_first",        2,     F_VS,   1});
        tbl.push_back('{"vs_last",         193,   F_VS,   1});
        tbl.push_back('{"vs_after",        194,   F_VS,   0});
        tbl.push_back('{"hs_pre",          177,   F_HS,   0});
        tbl.push_back('{"hs_start",        178,   F_HS,   1});
        tbl.push_back('{"hs_end",          185,   F_HS,   1});
        tbl.push_back('{"hs_after",        186,   F_HS,   0});
        tbl.push_back('{"rden_first",      768,   F_RDEN, 1});
        tbl.push_back('{"addr_first",      768,   F_ADDR, 0});
        tbl.push_back('{"de_pre",          769,   F_DE,   0});
        tbl.push_back('{"de_first",        770,   F_DE,   1});
        tbl.push_back('{"data_first",      770,   F_DATA, 8'h00});
        tbl.push_back('{"data_px175",      945,   F_DATA, 8'hAF});
        tbl.push_back('{"de_line_end",     946,   F_DE,   0});
        tbl.push_back('{"addr_last",       28399, F_ADDR, 25343});
        tbl.push_back('{"de_last",         28401, F_DE,   1});
        tbl.push_back('{"data_last",       28401, F_DATA, 8'hFF});
        tbl.push_back('{"de_after_last",   28402, F_DE,   0});
        tbl.push_back('{"busy_during",     5001,  F_BUSY, 1});
        tbl.push_back('{"done_pre",        28416, F_DONE, 0});
        tbl.push_back('{"done",            28417, F_DONE, 1});
        tbl.push_back('{"busy_at_done",    28417, F_BUSY, 1});
        tbl.push_back('{"busy_after",      28418, F_BUSY, 0});
        tbl.push_back('{"restart_ignored", NCAP - 1, F_BUSY, 0});

        start_frame();
        capture(NCAP, 1'b1);
        check_table();
        check_model("frame_ramp", NCAP, 1'b0);

        n_de = 0; n_rd = 0; n_vs = 0; n_hsp = 0;
        for (int c = 0; c < NCAP; c++) begin
            n_de += int'(trace[c].de);
            n_rd += int'(trace[c].rden);
            n_vs += int'(trace[c].vs);
            if (c > 0 && trace[c].hs && !trace[c-1].hs) n_hsp++;
        end
        chk("count_de", 0, 32'(n_de), 32'(NPIX));
        chk("count_rden", 0, 32'(n_rd), 32'(NPIX));
        chk("count_vsync", 0, 32'(n_vs), 32'd192);
        chk("count_hsync_pulses", 0, 32'(n_hsp), 32'd148);

        // Frame 2: random memory, aborted by a 1-cycle reset at cycle 10000.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        start_frame();
        capture(10000, 1'b0);
        check_model("frame_pre_reset", 10000, 1'b0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
        chk("reset_mid_outputs", 10001, 32'(sample_now()), 32'd0);
        n_bad = 0;
        for (int c = 0; c < 300; c++) begin
            @(negedge clk);
            if (busy || rd_en || vid.de || vid.vsync || vid.hsync) n_bad++;
        end
        chk("no_resume", 0, 32'(n_bad), 32'd0);

        // Frame 3: fresh random contents, full frame from address 0.
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
        start_frame();
        capture(NCAP, 1'b0);
        chk("addr_restart", 768, 32'(trace[768].addr), 32'd0);
        check_model("frame_rand", NCAP, 1'b0);

`ifdef VIDEO_STREAM_SRC_PATTERN_EN
        // Pattern frame; i_pattern dropped right after acceptance must stay latched.
        pattern = 1'b1;
        start_frame();
        pattern = 1'b0;
        capture(20200, 1'b0);
        check_model("frame_pattern", 20200, 1'b1);
        chk("pattern_r100_c170", 20140, 32'(trace[20140].data), 32'h0E);
        n_rd = 0;
        for (int c = 0; c < 20200; c++) n_rd += int'(trace[c].rden);
        chk("pattern_no_rden", 0, 32'(n_rd), 32'd0);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
